// File: rtl/fifo_main_pop_ctrl.sv
// Pop controller between the Main FIFO and the per-VC demux: issues reads, routes
// each word by its VC field and parks a word in a one-entry hold register under backpressure.
module fifo_main_pop_ctrl #(
  parameter int DATA_W    = 6,
  parameter int NUM_VC    = 2,
  parameter int VC_LSB    = 4,
  parameter int VC_W      = 1,
  parameter int STALL_ALL = 0,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              Main_empty,
  input  logic [DATA_W-1:0] Main_data_out,
  input  logic [NUM_VC-1:0] VC_almost_full,
  output logic              Main_rd,
  output logic [DATA_W-1:0] demux_vcid_in,
  output logic              demux_vcid_valid_in,
  output logic              vc_err,
  output logic [CNT_W-1:0]  pop_count
);

  localparam int VC_SPAN = 1 << VC_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_rd_pend;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state;
  logic [DATA_W-1:0]   w_hold;
  logic [DATA_W-1:0]   w_data;
  logic                w_valid;
  logic                w_err;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_stall_all;
  logic                w_head_blk;

  function automatic logic vc_bad_f(input logic [DATA_W-1:0] w);
    logic [31:0] v;
    v = 32'(w[VC_LSB +: VC_W]);
    return (v >= 32'(NUM_VC));
  endfunction

  // Out-of-range VC ids index a zero-padded flag vector, so they never block.
  function automatic logic blocked_f(input logic [DATA_W-1:0] w,
                                     input logic [NUM_VC-1:0] af);
    logic [VC_SPAN-1:0] ext;
    ext = VC_SPAN'(af);
    if (STALL_ALL != 0) begin
      return |af;
    end else begin
      return ext[w[VC_LSB +: VC_W]];
    end
  endfunction

  assign w_stall_all = (STALL_ALL != 0) ? (|VC_almost_full) : 1'b0;
  assign w_head_blk  = r_rd_pend & blocked_f(Main_data_out, VC_almost_full);

  assign Main_rd = reset_L & ~Main_empty & (r_state != S_HOLD) & ~w_head_blk & ~w_stall_all;

  assign demux_vcid_in       = r_data;
  assign demux_vcid_valid_in = r_valid;
  assign vc_err              = r_err;
  assign pop_count           = r_cnt;

  always_comb begin
    w_state = r_state;
    w_hold  = r_hold;
    w_data  = '0;
    w_valid = 1'b0;
    w_err   = 1'b0;
    w_cnt   = r_cnt;
    case (r_state)
      S_HOLD: begin
        if (!blocked_f(r_hold, VC_almost_full)) begin
          w_data  = r_hold;
          w_valid = 1'b1;
          w_cnt   = r_cnt + CNT_ONE;
          w_state = S_RUN;
        end else begin
          w_state = S_HOLD;
        end
      end
      S_IDLE, S_RUN: begin
        if (r_rd_pend) begin
          if (vc_bad_f(Main_data_out)) begin
            w_err   = 1'b1;
            w_state = S_RUN;
          end else if (!blocked_f(Main_data_out, VC_almost_full)) begin
            w_data  = Main_data_out;
            w_valid = 1'b1;
            w_cnt   = r_cnt + CNT_ONE;
            w_state = S_RUN;
          end else begin
            w_hold  = Main_data_out;
            w_state = S_HOLD;
          end
        end else begin
          w_state = r_state;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= S_IDLE;
      r_rd_pend <= 1'b0;
      r_hold    <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_rd_pend <= Main_rd;
      r_hold    <= w_hold;
      r_data    <= w_data;
      r_valid   <= w_valid;
      r_err     <= w_err;
      r_cnt     <= w_cnt;
    end
  end

endmodule

// File: tb/tb_fifo_main_pop_ctrl.sv
// Scoreboard bench: two controller instances (default 2-VC stall-own, and 3-VC stall-all
// with a 2-bit counter) each fed by a small Main FIFO model.
module tb_fifo_main_pop_ctrl;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [1:0] a_af;
  logic [2:0] b_af;
  logic       a_empty, b_empty, a_rd, b_rd;
  logic [5:0] a_dout = '0, b_dout = '0;
  logic [5:0] a_data, b_data;
  logic       a_valid, b_valid, a_err, b_err;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

  logic [5:0] mem_a [0:31];
  logic [5:0] mem_b [0:31];
  logic [4:0] wp_a = '0, rp_a = '0, wp_b = '0, rp_b = '0;
  logic [5:0] exp_a [$];
  logic [5:0] exp_b [$];
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fifo_main_pop_ctrl dut_a (
    .clk(clk), .reset_L(rst_l), .Main_empty(a_empty), .Main_data_out(a_dout),
    .VC_almost_full(a_af), .Main_rd(a_rd), .demux_vcid_in(a_data),
    .demux_vcid_valid_in(a_valid), .vc_err(a_err), .pop_count(a_cnt)
  );

  fifo_main_pop_ctrl #(.NUM_VC(3), .VC_W(2), .CNT_W(2), .STALL_ALL(1)) dut_b (
    .clk(clk), .reset_L(rst_l), .Main_empty(b_empty), .Main_data_out(b_dout),
    .VC_almost_full(b_af), .Main_rd(b_rd), .demux_vcid_in(b_data),
    .demux_vcid_valid_in(b_valid), .vc_err(b_err), .pop_count(b_cnt)
  );

  assign a_empty = (wp_a == rp_a);
  assign b_empty = (wp_b == rp_b);

  // Main FIFO models with one-cycle read latency
  always @(posedge clk) begin
    if (a_rd) begin
      a_dout <= mem_a[rp_a];
      rp_a   <= rp_a + 5'd1;
    end
    if (b_rd) begin
      b_dout <= mem_b[rp_b];
      rp_b   <= rp_b + 5'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [5:0] w, input bit delivered);
    mem_a[wp_a] = w;
    wp_a = wp_a + 5'd1;
    if (delivered) exp_a.push_back(w);
  endtask

  task automatic push_b(input logic [5:0] w, input bit delivered);
    mem_b[wp_b] = w;
    wp_b = wp_b + 5'd1;
    if (delivered) exp_b.push_back(w);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 40) begin
      nxt();
      k++;
    end
    chk(nm, 32'(exp_a.size() + exp_b.size()), 32'd0);
    nxt();
    nxt();
  endtask

  // Monitor: every delivered word must match the head of its scoreboard queue
  always @(negedge clk) begin : mon
    logic [5:0] e;
    if (a_valid) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected_word", 32'(a_data), 32'hffff_ffff);
      end else begin
        e = exp_a.pop_front();
        chk("a_word", 32'(a_data), 32'(e));
      end
    end else begin
      chk("a_idle_data", 32'(a_data), 32'd0);
    end
    chk("a_no_vc_err", 32'(a_err), 32'd0);
    if (b_valid) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected_word", 32'(b_data), 32'hffff_ffff);
      end else begin
        e = exp_b.pop_front();
        chk("b_word", 32'(b_data), 32'(e));
      end
    end else begin
      chk("b_idle_data", 32'(b_data), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_l = 1'b0;
    a_af  = 2'b00;
    b_af  = 3'b000;
    @(negedge clk);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_data",  32'(a_data),  32'd0);
    chk("rst_a_cnt",   32'(a_cnt),   32'd0);
    chk("rst_a_rd",    32'(a_rd),    32'd0);
    chk("rst_b_cnt",   32'(b_cnt),   32'd0);
    chk("rst_b_err",   32'(b_err),   32'd0);
    nxt();
    rst_l = 1'b1;
    nxt();

    // streaming: valid on cycles 2..4 after the first read
    push_a(6'h01, 1'b1);
    push_a(6'h12, 1'b1);
    push_a(6'h03, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("stream_rd_first", 32'(a_rd), 32'd1);
      chk("stream_valid_cycle", 32'(a_valid), 32'((i >= 2) && (i <= 4)));
      nxt();
    end
    drain("stream_drain");
    @(negedge clk);
    chk("stream_cnt", 32'(a_cnt), 32'd3);

    // own-VC stall: 6'h13 parks while VC1 almost full, 6'h05 follows it
    nxt();
    a_af = 2'b10;
    push_a(6'h13, 1'b1);
    push_a(6'h05, 1'b1);
    @(negedge clk); chk("hold_rd_c0", 32'(a_rd), 32'd1);
    nxt();
    @(negedge clk); chk("hold_rd_c1", 32'(a_rd), 32'd0);
    nxt();
    @(negedge clk); chk("hold_rd_c2", 32'(a_rd), 32'd0);
    chk("hold_valid_c2", 32'(a_valid), 32'd0);
    nxt();
    a_af = 2'b00;
    @(negedge clk); chk("hold_rd_release_cycle", 32'(a_rd), 32'd0);
    nxt();
    @(negedge clk); chk("hold_released_valid", 32'(a_valid), 32'd1);
    chk("hold_rd_resumes", 32'(a_rd), 32'd1);
    drain("hold_drain");
    @(negedge clk);
    chk("hold_cnt", 32'(a_cnt), 32'd5);

    // VC0 words pass while only VC1 is almost full
    nxt();
    a_af = 2'b10;
    push_a(6'h02, 1'b1);
    push_a(6'h03, 1'b1);
    @(negedge clk); chk("nostall_rd_c0", 32'(a_rd), 32'd1);
    nxt();
    @(negedge clk); chk("nostall_rd_c1", 32'(a_rd), 32'd1);
    drain("nostall_drain");
    @(negedge clk);
    chk("nostall_cnt", 32'(a_cnt), 32'd7);
    a_af = 2'b00;

    // stall-all: no read at all while any flag is set
    nxt();
    b_af = 3'b010;
    push_b(6'h02, 1'b1);
    @(negedge clk); chk("stallall_rd_c0", 32'(b_rd), 32'd0);
    repeat (3) nxt();
    @(negedge clk); chk("stallall_rd_c3", 32'(b_rd), 32'd0);
    chk("stallall_valid_c3", 32'(b_valid), 32'd0);
    nxt();
    b_af = 3'b000;
    @(negedge clk); chk("stallall_rd_clear", 32'(b_rd), 32'd1);
    drain("stallall_drain");
    @(negedge clk);
    chk("stallall_cnt", 32'(b_cnt), 32'd1);

    // VC id 3 with NUM_VC=3: single-cycle vc_err, dropped, not counted
    nxt();
    push_b(6'h30, 1'b0);
    @(negedge clk); chk("vcerr_rd_c0", 32'(b_rd), 32'd1);
    nxt();
    nxt();
    @(negedge clk); chk("vcerr_pulse", 32'(b_err), 32'd1);
    chk("vcerr_no_valid", 32'(b_valid), 32'd0);
    nxt();
    @(negedge clk); chk("vcerr_pulse_end", 32'(b_err), 32'd0);
    chk("vcerr_cnt", 32'(b_cnt), 32'd1);

    // four more deliveries: five in total wraps the 2-bit counter to 1
    nxt();
    push_b(6'h00, 1'b1);
    push_b(6'h11, 1'b1);
    push_b(6'h22, 1'b1);
    push_b(6'h01, 1'b1);
    drain("wrap_drain");
    @(negedge clk);
    chk("wrap_cnt", 32'(b_cnt), 32'd1);

    // reset while 6'h13 is parked: the held word is lost, 6'h04 is read afterwards
    nxt();
    a_af = 2'b10;
    push_a(6'h13, 1'b0);
    push_a(6'h04, 1'b1);
    nxt();
    nxt();
    @(negedge clk); chk("midrst_hold_rd", 32'(a_rd), 32'd0);
    nxt();
    rst_l = 1'b0;
    @(negedge clk);
    chk("midrst_rd",    32'(a_rd),    32'd0);
    chk("midrst_valid", 32'(a_valid), 32'd0);
    chk("midrst_data",  32'(a_data),  32'd0);
    chk("midrst_cnt",   32'(a_cnt),   32'd0);
    nxt();
    rst_l = 1'b1;
    @(negedge clk); chk("postrst_rd", 32'(a_rd), 32'd1);
    drain("postrst_drain");
    @(negedge clk);
    chk("postrst_cnt", 32'(a_cnt), 32'd1);
    a_af = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
